// File: rtl/demux12_tdm.sv
// Two-channel TDM serial demultiplexer: routes tagged bits to channel A or B,
// deserializes each into WIDTH-bit words (MSB first) with valid/ack and sticky overflow.

module demux12_tdm_chan #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLR,
   input  logic             cap,
   input  logic             din,
   input  logic             ack,
   output logic [WIDTH-1:0] out,
   output logic             vld,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t           state;
   logic [WIDTH-2:0] shreg;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] cand;
   logic             last;

   assign cand = {shreg, din};
   assign last = (cnt == CNT_W'(WIDTH - 1));
   assign vld  = (state == FULL);

   // Capture, completion and handshake for one channel; CLR blocks capture but not ACK.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= EMPTY;
         shreg <= '0;
         cnt   <= '0;
         out   <= '0;
         ovf   <= 1'b0;
      end else if (CLR) begin
         shreg <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
         if (ack) state <= EMPTY;
         else     state <= state;
      end else if (cap && last) begin
         cnt   <= '0;
         shreg <= '0;
         case (state)
            EMPTY: begin
               out   <= cand;
               state <= FULL;
            end
            FULL: begin
               // A simultaneous ACK frees the slot, so the new word streams in.
               if (ack) out <= cand;
               else     ovf <= 1'b1;
            end
            default: state <= EMPTY;
         endcase
      end else begin
         if (cap) begin
            cnt   <= cnt + CNT_W'(1);
            shreg <= cand[WIDTH-2:0];
         end else begin
            cnt   <= cnt;
         end
         if (ack) state <= EMPTY;
         else     state <= state;
      end
   end

endmodule

module demux12_tdm #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLR,
   input  logic             EN,
   input  logic             SEL,
   input  logic             DIN,
   input  logic             ACK_A,
   input  logic             ACK_B,
   output logic [WIDTH-1:0] OUT_A,
   output logic             VLD_A,
   output logic             OVF_A,
   output logic [WIDTH-1:0] OUT_B,
   output logic             VLD_B,
   output logic             OVF_B
);

   logic cap_a;
   logic cap_b;

   assign cap_a = EN & ~SEL;
   assign cap_b = EN & SEL;

   demux12_tdm_chan #(.WIDTH(WIDTH)) u_chan_a (
      .CLK (CLK),
      .RST (RST),
      .CLR (CLR),
      .cap (cap_a),
      .din (DIN),
      .ack (ACK_A),
      .out (OUT_A),
      .vld (VLD_A),
      .ovf (OVF_A)
   );

   demux12_tdm_chan #(.WIDTH(WIDTH)) u_chan_b (
      .CLK (CLK),
      .RST (RST),
      .CLR (CLR),
      .cap (cap_b),
      .din (DIN),
      .ack (ACK_B),
      .out (OUT_B),
      .vld (VLD_B),
      .ovf (OVF_B)
   );

endmodule

// File: tb/tb_demux12_tdm.sv
// Bench for demux12_tdm: directed vector table, async-reset sequence, and
// randomized traffic against a word-accumulating reference model.

module tb_demux12_tdm;

   localparam int WIDTH = 4;

   logic             CLK;
   logic             RST;
   logic             CLR;
   logic             EN;
   logic             SEL;
   logic             DIN;
   logic             ACK_A;
   logic             ACK_B;
   logic [WIDTH-1:0] OUT_A;
   logic             VLD_A;
   logic             OVF_A;
   logic [WIDTH-1:0] OUT_B;
   logic             VLD_B;
   logic             OVF_B;

   int checks;
   int failures;

   // Reference model state per channel (0 = A, 1 = B).
   int m_acc [2];
   int m_n   [2];
   int m_out [2];
   int m_vld [2];
   int m_ovf [2];

   typedef struct {
      logic       en, sel, din, ack_a, ack_b, clr;
      logic [3:0] oa;
      logic       va, fa;
      logic [3:0] ob;
      logic       vb, fb;
   } vec_t;

   vec_t tv[$];

   demux12_tdm #(.WIDTH(WIDTH)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .CLR   (CLR),
      .EN    (EN),
      .SEL   (SEL),
      .DIN   (DIN),
      .ACK_A (ACK_A),
      .ACK_B (ACK_B),
      .OUT_A (OUT_A),
      .VLD_A (VLD_A),
      .OVF_A (OVF_A),
      .OUT_B (OUT_B),
      .VLD_B (VLD_B),
      .OVF_B (OVF_B)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_acc[c] = 0;
         m_n[c]   = 0;
         m_out[c] = 0;
         m_vld[c] = 0;
         m_ovf[c] = 0;
      end
   endtask

   // Word-level behaviour: bits accumulate arithmetically until WIDTH have arrived.
   task automatic model_edge();
      int  word;
      bit  done;
      bit  ack;
      bit  cap;
      for (int c = 0; c < 2; c++) begin
         ack  = (c == 0) ? ACK_A : ACK_B;
         cap  = EN && !CLR && (int'(SEL) == c);
         done = 1'b0;
         word = 0;
         if (CLR) begin
            m_acc[c] = 0;
            m_n[c]   = 0;
            m_ovf[c] = 0;
         end else if (cap) begin
            m_acc[c] = m_acc[c] * 2 + int'(DIN);
            m_n[c]   = m_n[c] + 1;
            if (m_n[c] == WIDTH) begin
               done     = 1'b1;
               word     = m_acc[c];
               m_acc[c] = 0;
               m_n[c]   = 0;
            end
         end
         if (done) begin
            if (m_vld[c] == 0) begin
               m_out[c] = word;
               m_vld[c] = 1;
            end else if (ack) begin
               m_out[c] = word;
            end else begin
               m_ovf[c] = 1;
            end
         end else if (ack && m_vld[c] != 0) begin
            m_vld[c] = 0;
         end
      end
   endtask

   task automatic model_cmp();
      chk("model_out_a", int'(OUT_A), m_out[0]);
      chk("model_vld_a", int'(VLD_A), m_vld[0]);
      chk("model_ovf_a", int'(OVF_A), m_ovf[0]);
      chk("model_out_b", int'(OUT_B), m_out[1]);
      chk("model_vld_b", int'(VLD_B), m_vld[1]);
      chk("model_ovf_b", int'(OVF_B), m_ovf[1]);
   endtask

   task automatic tick();
      @(posedge CLK);
      model_edge();
      #1;
      model_cmp();
   endtask

   task automatic drive(input logic en, input logic sel, input logic din,
                        input logic aa, input logic ab, input logic clr);
      EN = en; SEL = sel; DIN = din; ACK_A = aa; ACK_B = ab; CLR = clr;
   endtask

   task automatic add(input logic en, input logic sel, input logic din,
                      input logic aa, input logic ab, input logic clr,
                      input logic [3:0] oa, input logic va, input logic fa,
                      input logic [3:0] ob, input logic vb, input logic fb);
      vec_t v;
      v.en = en; v.sel = sel; v.din = din; v.ack_a = aa; v.ack_b = ab; v.clr = clr;
      v.oa = oa; v.va = va; v.fa = fa; v.ob = ob; v.vb = vb; v.fb = fb;
      tv.push_back(v);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      model_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      RST = 1'b1;
      #12;
      chk("reset_out_a", int'(OUT_A), 0);
      chk("reset_vld_a", int'(VLD_A), 0);
      chk("reset_ovf_a", int'(OVF_A), 0);
      chk("reset_out_b", int'(OUT_B), 0);
      chk("reset_vld_b", int'(VLD_B), 0);
      chk("reset_ovf_b", int'(OVF_B), 0);
      RST = 1'b0;

      // en sel din ackA ackB clr | outA vA fA | outB vB fB
      add(1,0,1, 0,0,0, 4'h0,0,0, 4'h0,0,0);
      add(0,0,0, 0,0,0, 4'h0,0,0, 4'h0,0,0);
      add(1,0,0, 0,0,0, 4'h0,0,0, 4'h0,0,0);
      add(0,1,1, 0,0,0, 4'h0,0,0, 4'h0,0,0);
      add(1,0,1, 0,0,0, 4'h0,0,0, 4'h0,0,0);
      add(1,0,1, 0,0,0, 4'hB,1,0, 4'h0,0,0);
      add(0,0,0, 1,0,0, 4'hB,0,0, 4'h0,0,0);
      add(1,0,0, 0,0,0, 4'hB,0,0, 4'h0,0,0);
      add(1,1,1, 0,0,0, 4'hB,0,0, 4'h0,0,0);
      add(1,0,1, 0,0,0, 4'hB,0,0, 4'h0,0,0);
      add(1,1,0, 0,0,0, 4'hB,0,0, 4'h0,0,0);
      add(1,0,1, 0,0,0, 4'hB,0,0, 4'h0,0,0);
      add(1,1,0, 0,0,0, 4'hB,0,0, 4'h0,0,0);
      add(1,0,0, 0,0,0, 4'h6,1,0, 4'h0,0,0);
      add(1,1,1, 0,0,0, 4'h6,1,0, 4'h9,1,0);
      add(0,0,0, 1,1,0, 4'h6,0,0, 4'h9,0,0);
      add(1,0,1, 0,0,0, 4'h6,0,0, 4'h9,0,0);
      add(1,0,1, 0,0,0, 4'h6,0,0, 4'h9,0,0);
      add(1,0,0, 0,0,0, 4'h6,0,0, 4'h9,0,0);
      add(1,0,0, 0,0,0, 4'hC,1,0, 4'h9,0,0);
      add(1,0,0, 0,0,0, 4'hC,1,0, 4'h9,0,0);
      add(1,0,0, 0,0,0, 4'hC,1,0, 4'h9,0,0);
      add(1,0,1, 0,0,0, 4'hC,1,0, 4'h9,0,0);
      add(1,0,1, 0,0,0, 4'hC,1,1, 4'h9,0,0);
      add(0,0,0, 1,0,0, 4'hC,0,1, 4'h9,0,0);
      add(0,0,0, 0,0,1, 4'hC,0,0, 4'h9,0,0);
      add(1,0,1, 0,0,0, 4'hC,0,0, 4'h9,0,0);
      add(1,0,1, 0,0,0, 4'hC,0,0, 4'h9,0,0);
      add(1,0,0, 0,0,0, 4'hC,0,0, 4'h9,0,0);
      add(1,0,0, 0,0,0, 4'hC,1,0, 4'h9,0,0);
      add(1,0,0, 0,0,0, 4'hC,1,0, 4'h9,0,0);
      add(1,0,1, 0,0,0, 4'hC,1,0, 4'h9,0,0);
      add(1,0,0, 0,0,0, 4'hC,1,0, 4'h9,0,0);
      add(1,0,1, 1,0,0, 4'h5,1,0, 4'h9,0,0);
      add(1,1,0, 0,0,0, 4'h5,1,0, 4'h9,0,0);
      add(1,1,1, 0,0,0, 4'h5,1,0, 4'h9,0,0);
      add(1,1,1, 0,0,0, 4'h5,1,0, 4'h9,0,0);
      add(1,1,1, 0,0,0, 4'h5,1,0, 4'h7,1,0);
      add(1,0,1, 0,0,0, 4'h5,1,0, 4'h7,1,0);
      add(1,0,1, 0,0,0, 4'h5,1,0, 4'h7,1,0);
      add(1,0,0, 1,0,1, 4'h5,0,0, 4'h7,1,0);
      add(1,0,1, 0,0,0, 4'h5,0,0, 4'h7,1,0);
      add(1,0,1, 0,0,0, 4'h5,0,0, 4'h7,1,0);
      add(1,0,1, 0,0,0, 4'h5,0,0, 4'h7,1,0);
      add(1,0,0, 0,0,0, 4'hE,1,0, 4'h7,1,0);

      @(negedge CLK);
      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].en, tv[i].sel, tv[i].din, tv[i].ack_a, tv[i].ack_b, tv[i].clr);
         tick();
         chk($sformatf("vec%0d_out_a", i), int'(OUT_A), int'(tv[i].oa));
         chk($sformatf("vec%0d_vld_a", i), int'(VLD_A), int'(tv[i].va));
         chk($sformatf("vec%0d_ovf_a", i), int'(OVF_A), int'(tv[i].fa));
         chk($sformatf("vec%0d_out_b", i), int'(OUT_B), int'(tv[i].ob));
         chk($sformatf("vec%0d_vld_b", i), int'(VLD_B), int'(tv[i].vb));
         chk($sformatf("vec%0d_ovf_b", i), int'(OVF_B), int'(tv[i].fb));
      end

      // Async reset mid-word with words loaded on both channels.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #3;
      RST = 1'b1;
      #1;
      chk("arst_out_a", int'(OUT_A), 0);
      chk("arst_vld_a", int'(VLD_A), 0);
      chk("arst_ovf_a", int'(OVF_A), 0);
      chk("arst_out_b", int'(OUT_B), 0);
      chk("arst_vld_b", int'(VLD_B), 0);
      chk("arst_ovf_b", int'(OVF_B), 0);
      model_reset();
      #1;
      RST = 1'b0;
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      chk("arst_partial_vld_a", int'(VLD_A), 0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      chk("arst_after_out_a", int'(OUT_A), 11);
      chk("arst_after_vld_a", int'(VLD_A), 1);

      // Randomized traffic: sparse ACKs first (overflow-heavy), then dense ACKs.
      for (int i = 0; i < 4000; i++) begin
         EN    = ($urandom_range(0, 3) != 0);
         SEL   = 1'($urandom_range(0, 1));
         DIN   = 1'($urandom_range(0, 1));
         if (i < 2000) begin
            ACK_A = ($urandom_range(0, 7) == 0);
            ACK_B = ($urandom_range(0, 7) == 0);
         end else begin
            ACK_A = ($urandom_range(0, 1) == 0);
            ACK_B = ($urandom_range(0, 1) == 0);
         end
         CLR   = ($urandom_range(0, 63) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
